// File: rtl/pwm_duty_ramp.sv
// Duty-cycle sequencer ahead of the pwm core: slews dc toward a clamped target,
// changing it only on frame boundaries so the core never sees a mid-period update.
module pwm_duty_ramp #(
  parameter int PERIOD      = 100,
  parameter int DC_MAX      = 100,
  parameter int STEP        = 1,
  parameter int STEP_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] target,
  input  logic       ramp_en,
  input  logic       hold,
  output logic [6:0] dc,
  output logic       frame_start,
  output logic       busy
);

  // state | meaning
  // IDLE  | dc == clamped target, no slew pending
  // UP    | dc <  clamped target, steps add STEP
  // DOWN  | dc >  clamped target, steps subtract STEP
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  localparam logic [15:0] FCNT_LAST = 16'(PERIOD - 1);
  localparam logic [7:0]  SCNT_LAST = 8'(STEP_FRAMES - 1);
  localparam logic [6:0]  DC_MAX_C  = 7'(DC_MAX);
  localparam logic [6:0]  STEP_C    = 7'(STEP);
  localparam logic [7:0]  STEP_X    = 8'(STEP);

  state_t      state;
  logic [15:0] fcnt_q, fcnt_d;
  logic [7:0]  scnt_q, scnt_d;
  logic [6:0]  dc_q, dc_d;
  logic        frame_start_q, frame_start_d;
  logic        busy_q, busy_d;

  logic [6:0]  tgt_c;
  logic        frame_tick, step_point;
  logic [7:0]  up_sum, dn_floor;

  assign tgt_c      = (target > DC_MAX_C) ? DC_MAX_C : target;
  assign frame_tick = (fcnt_q == FCNT_LAST);
  assign step_point = frame_tick && (scnt_q == SCNT_LAST);

  // 8-bit arithmetic so neither the sum nor the threshold can wrap
  assign up_sum   = {1'b0, dc_q} + STEP_X;
  assign dn_floor = {1'b0, tgt_c} + STEP_X;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q        <= '0;
      scnt_q        <= '0;
      dc_q          <= '0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      fcnt_q        <= fcnt_d;
      scnt_q        <= scnt_d;
      dc_q          <= dc_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  // Direction follows dc and the live target every cycle, so reversals cost nothing.
  always_comb begin
    state = IDLE;
    if (dc_q < tgt_c)      state = UP;
    else if (dc_q > tgt_c) state = DOWN;
  end

  always_comb begin
    fcnt_d        = frame_tick ? 16'd0 : fcnt_q + 16'd1;
    frame_start_d = frame_tick;
    scnt_d        = scnt_q;
    dc_d          = dc_q;
    if (frame_tick && !hold) begin
      if (!ramp_en) begin
        dc_d   = tgt_c;
        scnt_d = '0;
      end else begin
        // scnt keeps counting in IDLE so a new ramp lands on the existing step grid
        scnt_d = step_point ? 8'd0 : scnt_q + 8'd1;
        if (step_point) begin
          case (state)
            UP:      dc_d = (up_sum > {1'b0, tgt_c}) ? tgt_c : up_sum[6:0];
            DOWN:    dc_d = ({1'b0, dc_q} >= dn_floor) ? (dc_q - STEP_C) : tgt_c;
            default: dc_d = dc_q;
          endcase
        end
      end
    end
    busy_d = (dc_d != tgt_c);
  end

  assign dc          = dc_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Randomized bench for pwm_duty_ramp: a frame/step-count reference model predicts
// dc, frame_start and busy after every clock edge, plus directed scenario checks.
module tb_pwm_duty_ramp;
  localparam int P  = 10;
  localparam int DM = 100;
  localparam int ST = 4;
  localparam int SF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] target = '0;
  logic       ramp_en = 1'b1;
  logic       hold = 1'b0;
  logic [6:0] dc;
  logic       frame_start;
  logic       busy;

  pwm_duty_ramp #(.PERIOD(P), .DC_MAX(DM), .STEP(ST), .STEP_FRAMES(SF)) dut (
    .clk(clk), .reset(reset), .target(target), .ramp_en(ramp_en), .hold(hold),
    .dc(dc), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model: edges since reset release, ramp frames counted since last reset / direct update
  int m_dc, m_busy, m_fs, m_edges, m_frames;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dc = 0; m_busy = 0; m_fs = 0; m_edges = 0; m_frames = 0;
  endtask

  // Called at a negedge with inputs settled; returns at the following negedge.
  task automatic cycle();
    int tgt;
    bit tick;
    tgt  = (int'(target) > DM) ? DM : int'(target);
    tick = ((m_edges + 1) % P == 0);
    m_edges++;
    m_fs = tick;
    if (tick && !hold) begin
      if (!ramp_en) begin
        m_dc = tgt;
        m_frames = 0;
      end else begin
        m_frames++;
        if (m_frames % SF == 0) begin
          if (m_dc < tgt)      m_dc = (m_dc + ST > tgt) ? tgt : m_dc + ST;
          else if (m_dc > tgt) m_dc = (m_dc - ST < tgt) ? tgt : m_dc - ST;
        end
      end
    end
    m_busy = (m_dc != tgt);
    @(posedge clk);
    #1;
    check("dc", 32'(dc), 32'(m_dc));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("busy", 32'(busy), 32'(m_busy));
    if (dc > 7'(DM)) check("dc_le_max", 32'(dc), 32'(DM));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("rst_dc", 32'(dc), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int wait_cnt;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_dc", 32'(dc), 32'd0);
    check("reset_frame_start", 32'(frame_start), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // soft-start 0 -> 20, one step every second frame
    target = 7'd20; ramp_en = 1'b1;
    for (int i = 1; i <= 110; i++) begin
      cycle();
      if (i == 10) check("tp1_first_frame", 32'(frame_start), 32'd1);
      if (i % 20 == 0 && i <= 100) check("tp1_step", 32'(dc), 32'(i / 20 * 4));
    end
    check("tp1_final_busy", 32'(busy), 32'd0);

    // clamp at DC_MAX, then a sub-step move down
    target = 7'd127;
    run(420);
    check("tp2_clamp", 32'(dc), 32'd100);
    target = 7'd98;
    run(40);
    check("tp2_down", 32'(dc), 32'd98);

    // direct mode with a mid-frame target change
    ramp_en = 1'b0;
    run(3);
    target = 7'd55;
    wait_cnt = 0;
    while (frame_start !== 1'b1 && wait_cnt < 3 * P) begin
      check("tp3_not_early", 32'(dc), 32'd98);
      cycle();
      wait_cnt++;
    end
    check("tp3_direct", 32'(dc), 32'd55);
    cycle();
    check("tp3_pulse_width", 32'(frame_start), 32'd0);

    // reversal during a ramp
    target = 7'd40;
    run(P);
    ramp_en = 1'b1; target = 7'd80;
    run(25);
    target = 7'd30;
    run(200);
    check("tp4_reversal_end", 32'(dc), 32'd30);

    // hold for five frames in the middle of a ramp
    target = 7'd90;
    run(35);
    hold = 1'b1;
    run(5 * P);
    hold = 1'b0;
    run(120);

    // async reset mid-frame
    ramp_en = 1'b0; target = 7'd60;
    run(P + 3);
    pulse_reset();
    run(P + 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) target = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 150) == 0) ramp_en = ~ramp_en;
      if ($urandom_range(0, 120) == 0) hold = ~hold;
      if ($urandom_range(0, 700) == 0) pulse_reset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule
